bit_deserializer: RTL and testbench



---
 rtl/bit_deserializer.sv | 164 ++++++++++++++++
 tb/tb_bit_deserializer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bit_deserializer.sv
// bit_deserializer: collects an LSB-first serial adder stream into a parallel
// word and captures the final carry. Both sides use valid/ready handshakes.
//
// Parameter: length - word width in bits (>= 1)
//
// Ports:
//   i_clk, i_rst_n    clock (rising edge), async active-low reset
//   i_bit_valid       serial bit present this cycle
//   i_bit_data        serial result bit
//   i_bit_first       marks the first bit of a word
//   i_bit_cout        adder carry-out, sampled with the last bit
//   o_bit_ready       deserializer can accept a bit
//   o_data_result     assembled word
//   o_data_valid      o_data_result / o_flag_carry valid
//   i_con_ready       consumer accepts the word
//   o_flag_carry      carry captured with the last bit
//   o_flag_err        one-cycle framing-error pulse
//
// Build option: BIT_DESER_MSB_FIRST_EN - fill from index length-1 downward;
// o_flag_carry is then tied to 0.
module bit_deserializer #(
  parameter int length = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_bit_valid,
  input  logic              i_bit_data,
  input  logic              i_bit_first,
  input  logic              i_bit_cout,
  output logic              o_bit_ready,
  output logic [length-1:0] o_data_result,
  output logic              o_data_valid,
  input  logic              i_con_ready,
  output logic              o_flag_carry,
  output logic              o_flag_err
);

  localparam int CW = (length > 1) ? $clog2(length) : 1;
  localparam logic [CW-1:0] LAST = CW'(length - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } state_t;

  state_t            state;
  state_t            nxt_state;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     nxt_cnt;
  logic [CW-1:0]     pos;
  logic [CW-1:0]     wr_idx;
  logic              accept;
  logic              wr_en;
  logic              last;
  logic              nxt_err;
  logic [length-1:0] data;
  logic              carry;
  logic              err;

  assign o_bit_ready = (state != HOLD);
  assign accept      = i_bit_valid && o_bit_ready;

  // A first-flagged bit always lands at word position 0, which is
  // also how a mid-word re-frame restarts the word.
  assign pos  = i_bit_first ? '0 : cnt;
  assign last = (pos == LAST);

`ifdef BIT_DESER_MSB_FIRST_EN
  assign wr_idx = LAST - pos;
`else
  assign wr_idx = pos;
`endif

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    wr_en     = 1'b0;
    nxt_err   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (i_bit_first) begin
            wr_en     = 1'b1;
            nxt_state = last ? HOLD : SHIFT;
            nxt_cnt   = last ? '0 : ONE;
          end else begin
            nxt_err = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (accept) begin
          wr_en   = 1'b1;
          nxt_err = i_bit_first;
          if (last) begin
            nxt_state = HOLD;
            nxt_cnt   = '0;
          end else begin
            nxt_state = SHIFT;
            nxt_cnt   = pos + ONE;
          end
        end
      end
      HOLD: begin
        if (i_con_ready) begin
          nxt_state = IDLE;
        end
      end
      default: begin
        nxt_state = IDLE;
        nxt_cnt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
      err   <= nxt_err;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data <= '0;
    end else if (wr_en) begin
      data[wr_idx] <= i_bit_data;
    end
  end

`ifdef BIT_DESER_MSB_FIRST_EN
  logic unused_cout;
  assign unused_cout = i_bit_cout;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      carry <= 1'b0;
    end else begin
      carry <= 1'b0;
    end
  end
`else
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      carry <= 1'b0;
    end else if (wr_en && last) begin
      carry <= i_bit_cout;
    end
  end
`endif

  assign o_data_result = data;
  assign o_data_valid  = (state == HOLD);
  assign o_flag_carry  = carry;
  assign o_flag_err    = err;

endmodule

// File: tb/tb_bit_deserializer.sv
// tb_bit_deserializer: directed bench for bit_deserializer (length=8)
// with a word-level reference model checked every cycle.
module tb_bit_deserializer;

`ifdef BIT_DESER_MSB_FIRST_EN
  localparam bit MSB = 1'b1;
`else
  localparam bit MSB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bv = 1'b0;
  logic       bd = 1'b0;
  logic       bf = 1'b0;
  logic       bc = 1'b0;
  logic       cr = 1'b0;
  logic       rdy;
  logic [7:0] res;
  logic       dv;
  logic       cy;
  logic       er;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;

  bit_deserializer #(.length(8)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_bit_valid  (bv),
    .i_bit_data   (bd),
    .i_bit_first  (bf),
    .i_bit_cout   (bc),
    .o_bit_ready  (rdy),
    .o_data_result(res),
    .o_data_valid (dv),
    .i_con_ready  (cr),
    .o_flag_carry (cy),
    .o_flag_err   (er)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  // Reference model: tracks the word being collected as a bit count
  // plus an accumulated value, and whether a finished word is held.
  bit         m_hold = 0;
  int         m_pos = 0;
  logic [7:0] m_word = '0;
  bit         m_carry = 0;
  bit         m_err = 0;

  always @(posedge clk) begin
    bit acc;
    bit e;
    if (!rst_n) begin
      m_hold = 0;
      m_pos = 0;
      m_word = '0;
      m_carry = 0;
      m_err = 0;
    end else begin
      acc = bv && !m_hold;
      e = 0;
      if (m_hold && cr) m_hold = 0;
      if (acc) begin
        if (bf) begin
          if (m_pos != 0) e = 1;
          m_pos = 0;
        end else if (m_pos == 0) begin
          e = 1;
          acc = 0;
        end
        if (acc) begin
          m_word[MSB ? 7 - m_pos : m_pos] = bd;
          m_pos++;
          if (m_pos == 8) begin
            m_pos = 0;
            m_hold = 1;
            m_carry = MSB ? 1'b0 : bc;
          end
        end
      end
      m_err = e;
    end
    #1;
    chk("m_valid", 32'(dv), 32'(m_hold));
    chk("m_ready", 32'(rdy), 32'(!m_hold));
    chk("m_err", 32'(er), 32'(m_err));
    if (m_hold) begin
      chk("m_result", 32'(res), 32'(m_word));
      chk("m_carry", 32'(cy), 32'(m_carry));
    end
    if (!rst_n) begin
      chk("m_rst_result", 32'(res), 32'h0);
      chk("m_rst_carry", 32'(cy), 32'h0);
    end
    if (er) err_seen++;
  end

  // b[i] is the i-th bit sent on the wire.
  task automatic send(input logic [7:0] b, input int n,
                      input logic cout, input int gap);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bv = 1'b1;
      bd = b[i];
      bf = (i == 0);
      bc = (i == 7) ? cout : 1'b0;
      if (gap > 0 && i < n - 1) begin
        @(negedge clk);
        bv = 1'b0;
        repeat (gap - 1) @(negedge clk);
      end
    end
    @(negedge clk);
    bv = 1'b0;
    bf = 1'b0;
    bc = 1'b0;
  endtask

  task automatic pop();
    cr = 1'b1;
    @(negedge clk);
    cr = 1'b0;
    chk("pop_valid", 32'(dv), 32'h0);
    chk("pop_ready", 32'(rdy), 32'h1);
  endtask

  initial begin
    int snap;
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(dv), 32'h0);
    chk("rst_ready", 32'(rdy), 32'h1);
    chk("rst_result", 32'(res), 32'h0);
    chk("rst_carry", 32'(cy), 32'h0);
    chk("rst_err", 32'(er), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1,0,1,0,0,1,0,1 with carry on the last bit -> A5
    send(8'hA5, 8, 1'b1, 0);
    chk("a5_valid", 32'(dv), 32'h1);
    chk("a5_result", 32'(res), 32'hA5);
    chk("a5_carry", 32'(cy), MSB ? 32'h0 : 32'h1);
    pop();

    // 3C held under back-pressure with stray bits offered
    send(8'h3C, 8, 1'b0, 1);
    for (int k = 0; k < 5; k++) begin
      bv = 1'b1;
      bd = k[0];
      bf = k[1];
      @(negedge clk);
      chk("hold_valid", 32'(dv), 32'h1);
      chk("hold_ready", 32'(rdy), 32'h0);
      chk("hold_err", 32'(er), 32'h0);
      chk("hold_result", 32'(res), 32'h3C);
    end
    bv = 1'b0;
    bf = 1'b0;
    pop();

    // Aborted 3-bit word, re-framed by a full 3C
    snap = err_seen;
    send(8'h07, 3, 1'b0, 0);
    send(8'h3C, 8, 1'b0, 0);
    chk("reframe_errs", 32'(err_seen - snap), 32'h1);
    chk("reframe_result", 32'(res), 32'h3C);
    chk("reframe_valid", 32'(dv), 32'h1);
    pop();

    // Stray non-first bit in IDLE
    @(negedge clk);
    bv = 1'b1;
    bd = 1'b1;
    bf = 1'b0;
    @(negedge clk);
    bv = 1'b0;
    chk("stray_err", 32'(er), 32'h1);
    chk("stray_valid", 32'(dv), 32'h0);
    @(negedge clk);
    chk("stray_err_clr", 32'(er), 32'h0);
    send(8'h96, 8, 1'b1, 2);
    chk("gap_result", 32'(res), MSB ? 32'h69 : 32'h96);
    chk("gap_carry", 32'(cy), MSB ? 32'h0 : 32'h1);
    pop();

    // Reset after 4 bits
    send(8'h0F, 4, 1'b0, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(dv), 32'h0);
    chk("mid_rst_result", 32'(res), 32'h0);
    chk("mid_rst_ready", 32'(rdy), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'hFF, 8, 1'b0, 0);
    chk("ff_result", 32'(res), 32'hFF);
    chk("ff_carry", 32'(cy), 32'h0);
    pop();

    // 0,0,0,0,0,0,0,1
    send(8'h80, 8, 1'b1, 0);
    chk("order_result", 32'(res), MSB ? 32'h01 : 32'h80);
    chk("order_carry", 32'(cy), MSB ? 32'h0 : 32'h1);
    pop();

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
